cpu_spi_regs: RTL

SPI slave and register file that sits directly upstream of the audio processing stage. It turns byte-oriented SPI transactions from the host CPU into the control registers that configure the audio pipeline: audio_control, filter_select, taps_per_filter, the coefficient and EQ write-data registers, and test_reg. It generates the single-cycle coef_wr_en and eq_wr_en strobes, and returns audio_status plus a captured test sample to the CPU.

---
 rtl/audipus_regs_pkg.sv | 25 ++
 rtl/spi_byte_shifter.sv | 94 +++++++++
 rtl/cpu_spi_regs.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/audipus_regs_pkg.sv
// Shared definitions for the CPU-facing SPI register slice of the audio pipeline:
// register addresses, the taps reset value and the SPI frame state machine encoding.
package audipus_regs_pkg;

  localparam logic [6:0] ADDR_AUDIO_CONTROL   = 7'h00;
  localparam logic [6:0] ADDR_FILTER_SELECT   = 7'h01;
  localparam logic [6:0] ADDR_TAPS_PER_FILTER = 7'h02;
  localparam logic [6:0] ADDR_COEF_WR_LSB     = 7'h03;
  localparam logic [6:0] ADDR_COEF_WR_MSB     = 7'h04;
  localparam logic [6:0] ADDR_EQ_WR_LSB       = 7'h05;
  localparam logic [6:0] ADDR_EQ_WR_MSB       = 7'h06;
  localparam logic [6:0] ADDR_AUDIO_STATUS    = 7'h07;
  localparam logic [6:0] ADDR_TEST_REG        = 7'h08;
  localparam logic [6:0] ADDR_TEST_CAPTURE    = 7'h09;

  localparam logic [7:0] TAPS_RESET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR,
    ST_RD
  } spi_state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Oversampling SPI mode-0 byte engine: synchronizes the pins into clk, detects sclk edges,
// assembles received bytes and shifts out a byte that the register file loads on demand.
module spi_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       load_tx,
  input  logic [7:0] tx_byte,
  output logic       cs_n_s,
  output logic       cs_fall,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso_bit
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_q;
  logic                   sclk_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             tx_shift;

  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_n_s;
  assign miso_bit  = tx_shift[7];

  // cs_n resets to "selected" so that a reset released mid-frame cannot look like a new frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_cs_n);
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      cs_q      <= cs_n_s;
      sclk_q    <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_n_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {rx_shift, mosi_s};
          byte_done <= 1'b1;
        end
      end
    end
  end

  // A falling edge with bit_cnt at zero always follows a completed byte, so that is the load slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '0;
    end else if (cs_n_s) begin
      tx_shift <= '0;
    end else if (sclk_fall) begin
      if (load_tx && (bit_cnt == 3'd0)) begin
        tx_shift <= tx_byte;
      end else begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/cpu_spi_regs.sv
// CPU-facing SPI slave and control register file for the audio stage: decodes
// {rw, addr} frames with auto-increment, drives the write strobes and returns status/capture data.
module cpu_spi_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TAPS_RESET  = audipus_regs_pkg::TAPS_RESET
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] audio_status,
  input  logic       test_dout_valid,
  input  logic [7:0] test_data_out,
  output logic [7:0] audio_control,
  output logic [7:0] filter_select,
  output logic [7:0] taps_per_filter,
  output logic [7:0] coef_wr_lsb_data,
  output logic [7:0] coef_wr_msb_data,
  output logic [7:0] eq_wr_lsb_data,
  output logic [7:0] eq_wr_msb_data,
  output logic [7:0] test_reg,
  output logic       coef_wr_en,
  output logic       eq_wr_en
);

  import audipus_regs_pkg::*;

  spi_state_t state;
  logic [6:0] addr;
  logic       armed;
  logic       coef_fire;
  logic       eq_fire;
  logic [7:0] test_capture;
  logic [7:0] tx_byte;
  logic       load_tx;
  logic       cs_n_s;
  logic       cs_fall;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       miso_bit;

  assign load_tx = (state == ST_RD);

  spi_byte_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .load_tx   (load_tx),
    .tx_byte   (tx_byte),
    .cs_n_s    (cs_n_s),
    .cs_fall   (cs_fall),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .miso_bit  (miso_bit)
  );

  // audio_status is read live here; the shifter captures it only at the load slot
  always_comb begin
    tx_byte = 8'h00;
    case (addr)
      ADDR_AUDIO_CONTROL:   tx_byte = audio_control;
      ADDR_FILTER_SELECT:   tx_byte = filter_select;
      ADDR_TAPS_PER_FILTER: tx_byte = taps_per_filter;
      ADDR_COEF_WR_LSB:     tx_byte = coef_wr_lsb_data;
      ADDR_COEF_WR_MSB:     tx_byte = coef_wr_msb_data;
      ADDR_EQ_WR_LSB:       tx_byte = eq_wr_lsb_data;
      ADDR_EQ_WR_MSB:       tx_byte = eq_wr_msb_data;
      ADDR_AUDIO_STATUS:    tx_byte = audio_status;
      ADDR_TEST_REG:        tx_byte = test_reg;
      ADDR_TEST_CAPTURE:    tx_byte = test_capture;
      default:              tx_byte = 8'h00;
    endcase
  end

  // armed only sets once cs_n is seen high, so a frame cut by reset is ignored until reselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      addr             <= '0;
      armed            <= 1'b0;
      coef_fire        <= 1'b0;
      eq_fire          <= 1'b0;
      coef_wr_en       <= 1'b0;
      eq_wr_en         <= 1'b0;
      audio_control    <= 8'h00;
      filter_select    <= 8'h00;
      taps_per_filter  <= TAPS_RESET;
      coef_wr_lsb_data <= 8'h00;
      coef_wr_msb_data <= 8'h00;
      eq_wr_lsb_data   <= 8'h00;
      eq_wr_msb_data   <= 8'h00;
      test_reg         <= 8'h00;
    end else begin
      coef_fire  <= 1'b0;
      eq_fire    <= 1'b0;
      coef_wr_en <= coef_fire;
      eq_wr_en   <= eq_fire;
      if (cs_n_s) begin
        state <= ST_IDLE;
        armed <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall && armed) begin
              state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              addr  <= rx_byte[6:0];
              state <= rx_byte[7] ? ST_RD : ST_WR;
            end
          end
          ST_WR: begin
            if (byte_done) begin
              addr <= addr + 7'd1;
              case (addr)
                ADDR_AUDIO_CONTROL:   audio_control    <= rx_byte;
                ADDR_FILTER_SELECT:   filter_select    <= rx_byte;
                ADDR_TAPS_PER_FILTER: taps_per_filter  <= rx_byte;
                ADDR_COEF_WR_LSB:     coef_wr_lsb_data <= rx_byte;
                ADDR_COEF_WR_MSB: begin
                  coef_wr_msb_data <= rx_byte;
                  coef_fire        <= 1'b1;
                end
                ADDR_EQ_WR_LSB:       eq_wr_lsb_data   <= rx_byte;
                ADDR_EQ_WR_MSB: begin
                  eq_wr_msb_data <= rx_byte;
                  eq_fire        <= 1'b1;
                end
                ADDR_TEST_REG:        test_reg         <= rx_byte;
                default: ;
              endcase
            end
          end
          ST_RD: begin
            if (byte_done) begin
              addr <= addr + 7'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_capture <= 8'h00;
    end else if (test_dout_valid) begin
      test_capture <= test_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_miso <= 1'b0;
    end else begin
      spi_miso <= (state == ST_RD) ? miso_bit : 1'b0;
    end
  end

endmodule
